// File: rtl/rf_pkg.sv
// Shared sizing constants for the register-file scoreboard.
package rf_pkg;
    localparam int unsigned NREGS  = 8;
    localparam int unsigned SELW   = 3;
    localparam int unsigned MAXINF = 3;
    localparam int unsigned CNTW   = 2;

    function automatic logic [NREGS-1:0] onehot(input logic [SELW-1:0] sel);
        onehot      = '0;
        onehot[sel] = 1'b1;
    endfunction
endpackage

// File: rtl/rf_scoreboard_sb_counter.sv
// Per-register in-flight write counter: up on issue, down on writeback.
module sb_counter
    import rf_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic zero,
    output logic full,
    output logic underflow
);

    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] count_d;

    always_comb begin
        zero      = (count_q == '0);
        full      = (count_q == CNTW'(MAXINF));
        // A retire paired with a same-register issue cancels out, even at zero.
        underflow = dec & ~inc & zero;
        count_d   = count_q;
        if (inc && !dec && !full) begin
            count_d = count_q + 1'b1;
        end else if (dec && !inc && !zero) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rf_scoreboard.sv
// Decode-stage scoreboard: stalls issue on pending writes to sources or a saturated destination.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic             issue_writes,
    input  logic [SELW-1:0]  issue_wsel,
    input  logic             issue_r1_used,
    input  logic [SELW-1:0]  issue_r1sel,
    input  logic             issue_r2_used,
    input  logic [SELW-1:0]  issue_r2sel,
    input  logic             wb_write,
    input  logic [SELW-1:0]  wb_sel,
    output logic             stall,
    output logic             issue_accept,
    output logic [NREGS-1:0] busy_vec,
    output logic             err
);

    logic [NREGS-1:0] inc_vec;
    logic [NREGS-1:0] dec_vec;
    logic [NREGS-1:0] zero_vec;
    logic [NREGS-1:0] full_vec;
    logic [NREGS-1:0] unf_vec;
    logic             haz1;
    logic             haz2;
    logic             hazw;
    logic             err_q;
    logic             err_d;

    for (genvar i = 0; i < NREGS; i++) begin : g_cnt
        sb_counter u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc_vec[i]),
            .dec       (dec_vec[i]),
            .zero      (zero_vec[i]),
            .full      (full_vec[i]),
            .underflow (unf_vec[i])
        );
    end

    // Hazards look only at registered counts; a same-cycle retire does not bypass.
    always_comb begin
        haz1         = issue_r1_used & ~zero_vec[issue_r1sel];
        haz2         = issue_r2_used & ~zero_vec[issue_r2sel];
        hazw         = issue_writes & full_vec[issue_wsel];
        stall        = issue_valid & (haz1 | haz2 | hazw);
        issue_accept = issue_valid & ~stall;
    end

    always_comb begin
        inc_vec = (issue_accept && issue_writes) ? onehot(issue_wsel) : '0;
        dec_vec = wb_write ? onehot(wb_sel) : '0;
    end

    always_comb begin
        err_d = err_q | (|unf_vec);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign busy_vec = ~zero_vec;
    assign err      = err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed plus randomized checks of rf_scoreboard against an array-of-counts model.
module tb_rf_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic       issue_writes;
    logic [2:0] issue_wsel;
    logic       issue_r1_used;
    logic [2:0] issue_r1sel;
    logic       issue_r2_used;
    logic [2:0] issue_r2sel;
    logic       wb_write;
    logic [2:0] wb_sel;
    logic       stall;
    logic       issue_accept;
    logic [7:0] busy_vec;
    logic       err;

    int checks = 0;
    int errors = 0;
    int cnt[8];
    bit err_m;
    logic last_stall;
    logic last_acc;

    always #5 clk = ~clk;

    rf_scoreboard dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_writes  (issue_writes),
        .issue_wsel    (issue_wsel),
        .issue_r1_used (issue_r1_used),
        .issue_r1sel   (issue_r1sel),
        .issue_r2_used (issue_r2_used),
        .issue_r2sel   (issue_r2sel),
        .wb_write      (wb_write),
        .wb_sel        (wb_sel),
        .stall         (stall),
        .issue_accept  (issue_accept),
        .busy_vec      (busy_vec),
        .err           (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        err_m = 1'b0;
    endtask

    // One clock cycle: drive, check combinational and registered outputs, advance model.
    task automatic step(input bit v, input bit w, input int ws, input bit u1, input int s1,
                        input bit u2, input int s2, input bit wb, input int wbs);
        bit         exp_stall;
        bit         exp_acc;
        bit         do_inc;
        logic [7:0] exp_busy;
        issue_valid   = v;
        issue_writes  = w;
        issue_wsel    = ws[2:0];
        issue_r1_used = u1;
        issue_r1sel   = s1[2:0];
        issue_r2_used = u2;
        issue_r2sel   = s2[2:0];
        wb_write      = wb;
        wb_sel        = wbs[2:0];
        #1;
        exp_stall = v && ((u1 && cnt[s1] != 0) || (u2 && cnt[s2] != 0) || (w && cnt[ws] == 3));
        exp_acc   = v && !exp_stall;
        for (int i = 0; i < 8; i++) exp_busy[i] = (cnt[i] != 0);
        chk("stall", {31'd0, stall}, {31'd0, exp_stall});
        chk("issue_accept", {31'd0, issue_accept}, {31'd0, exp_acc});
        chk("busy_vec", {24'd0, busy_vec}, {24'd0, exp_busy});
        chk("err", {31'd0, err}, {31'd0, err_m});
        last_stall = stall;
        last_acc   = issue_accept;
        @(posedge clk);
        do_inc = exp_acc && w;
        if (do_inc && wb && ws == wbs) begin
            // paired issue and retire on one register: no change
        end else begin
            if (do_inc) cnt[ws]++;
            if (wb) begin
                if (cnt[wbs] == 0) err_m = 1'b1;
                else cnt[wbs]--;
            end
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asserts reset between edges while a hazardous issue is presented.
    task automatic do_reset(input int busy_reg);
        rst           = 1'b1;
        issue_valid   = 1'b1;
        issue_writes  = 1'b1;
        issue_wsel    = 3'(busy_reg);
        issue_r1_used = 1'b1;
        issue_r1sel   = 3'(busy_reg);
        issue_r2_used = 1'b0;
        issue_r2sel   = 3'd0;
        wb_write      = 1'b0;
        wb_sel        = 3'd0;
        #1;
        chk("rst_busy", {24'd0, busy_vec}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        model_clear();
        issue_valid = 0; issue_writes = 0; issue_wsel = 0;
        issue_r1_used = 0; issue_r1sel = 0; issue_r2_used = 0; issue_r2sel = 0;
        wb_write = 0; wb_sel = 0;
        #12;
        chk("init_busy", {24'd0, busy_vec}, 32'd0);
        chk("init_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        idle();

        // RAW on R3
        step(1, 1, 3, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 3, 0, 0, 0, 0);
        chk("raw_stall", {31'd0, last_stall}, 32'd1);
        step(1, 0, 0, 1, 3, 0, 0, 1, 3);
        chk("raw_wb_cycle", {31'd0, last_stall}, 32'd1);
        step(1, 0, 0, 1, 3, 0, 0, 0, 0);
        chk("raw_after_wb", {31'd0, last_stall}, 32'd0);

        // Saturation on R5
        for (int i = 0; i < 3; i++) step(1, 1, 5, 0, 0, 0, 0, 0, 0);
        step(1, 1, 5, 0, 0, 0, 0, 0, 0);
        chk("sat_stall", {31'd0, last_stall}, 32'd1);
        step(1, 1, 5, 0, 0, 0, 0, 1, 5);
        chk("sat_wb_cycle", {31'd0, last_stall}, 32'd1);
        step(1, 1, 5, 0, 0, 0, 0, 0, 0);
        chk("sat_accept", {31'd0, last_acc}, 32'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 5);

        // Simultaneous issue and retire on R2
        step(1, 1, 2, 0, 0, 0, 0, 0, 0);
        step(1, 1, 2, 0, 0, 0, 0, 1, 2);
        chk("sim_accept", {31'd0, last_acc}, 32'd1);
        chk("sim_busy2", {31'd0, busy_vec[2]}, 32'd1);
        chk("sim_err", {31'd0, err}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 2);
        chk("sim_drained", {31'd0, busy_vec[2]}, 32'd0);
        chk("sim_noerr", {31'd0, err}, 32'd0);

        // Mid-run reset with R1 busy, then accept right after release
        step(1, 1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 6, 0, 0, 0, 0, 0, 0);
        do_reset(1);
        step(1, 1, 1, 1, 1, 1, 6, 0, 0);
        chk("post_rst_accept", {31'd0, last_acc}, 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);

        // Underflow on R7 is sticky
        step(0, 0, 0, 0, 0, 0, 0, 1, 7);
        chk("unf_err", {31'd0, err}, 32'd1);
        step(1, 1, 4, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 4);
        chk("unf_sticky", {31'd0, err}, 32'd1);
        do_reset(4);
        chk("unf_cleared", {31'd0, err}, 32'd0);

        // Unused sources and two-source hazards
        step(1, 1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 4, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 4, 0, 0);
        chk("unused_src", {31'd0, last_stall}, 32'd0);
        step(1, 0, 0, 1, 1, 1, 4, 1, 1);
        chk("two_src_a", {31'd0, last_stall}, 32'd1);
        step(1, 0, 0, 1, 1, 1, 4, 1, 4);
        chk("two_src_b", {31'd0, last_stall}, 32'd1);
        step(1, 0, 0, 1, 1, 1, 4, 0, 0);
        chk("two_src_clear", {31'd0, last_stall}, 32'd0);

        // Random traffic; retires mostly target busy registers
        for (int n = 0; n < 400; n++) begin
            int  ws, s1, s2, wbs;
            bit  wb;
            ws  = $urandom_range(7);
            s1  = $urandom_range(7);
            s2  = $urandom_range(7);
            wbs = $urandom_range(7);
            wb  = ($urandom_range(1) == 1);
            if (wb && cnt[wbs] == 0 && $urandom_range(15) != 0) wb = 0;
            if ($urandom_range(99) == 0) do_reset(ws);
            step($urandom_range(3) != 0, $urandom_range(3) != 0, ws,
                 $urandom_range(1) == 1, s1, $urandom_range(1) == 1, s2, wb, wbs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
